// File: rtl/dct_2d_sequencer.sv
`timescale 1ns/1ps
// dct_2d_sequencer
// Purpose : runs one 8x8 2-D DCT through a shared 8-point butterfly. Eight input
//           rows go through the butterfly into a transpose buffer, then the eight
//           buffer columns go through it again, and the coefficient block is
//           emitted row-major. The sequencer does no arithmetic.
// Latency : the first output row is valid 17 + 2*BF_LATENCY cycles after the
//           first input handshake when the input rows arrive back-to-back.
// Backpressure: IN_READY is high only in IDLE/ROW_FEED. Output rows advance only
//           on OUT_VALID & OUT_READY and hold steady while stalled.
// Ports   : CLOCK/RESET (async, active high); IN_VALID/IN_READY/IN_ROW input rows;
//           BF_DATA -> butterfly DATA, BF_OUT <- butterfly OUT_DATA;
//           OUT_VALID/OUT_READY/OUT_ROW/OUT_LAST coefficient rows; BUSY = not IDLE.
// Option  : DCT_SEQ_PERF_CNT_EN adds a 32-bit BLOCK_COUNT output that counts
//           completed blocks (row-7 output handshakes) and wraps.
module dct_2d_sequencer #(
    parameter int DW         = 32,
    parameter int BF_LATENCY = 5
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [7:0][DW-1:0]   IN_ROW,
    output logic [7:0][DW-1:0]   BF_DATA,
    input  logic [7:0][DW-1:0]   BF_OUT,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [7:0][DW-1:0]   OUT_ROW,
    output logic                 OUT_LAST,
`ifdef DCT_SEQ_PERF_CNT_EN
    output logic [31:0]          BLOCK_COUNT,
`endif
    output logic                 BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_FEED,
        S_ROW_DRAIN,
        S_COL_FEED,
        S_COL_DRAIN,
        S_OUTPUT
    } state_t;

    // Tag layout: [4] valid, [3] pass (0 = row, 1 = column), [2:0] index.
    localparam int TAG_W = 5;

    state_t             state_q, state_d;
    logic [2:0]         row_cnt_q, row_cnt_d;
    logic [2:0]         col_cnt_q, col_cnt_d;
    logic [2:0]         out_cnt_q, out_cnt_d;
    logic [7:0][DW-1:0] bf_data_q, bf_data_d;
    logic [TAG_W-1:0]   bf_tag_q, bf_tag_d;
    logic [TAG_W-1:0]   tag_pipe_q [0:BF_LATENCY-1];

    // Transpose buffer: mem_q[row][col]. Not reset; every word is rewritten
    // by the row pass before it is read.
    logic [DW-1:0]      mem_q [0:7][0:7];

    logic               in_hs;
    logic               out_hs;
    logic [TAG_W-1:0]   tag_out;
    logic               cap_vld;
    logic               cap_col;
    logic [2:0]         cap_idx;
    logic               cap_row7;
    logic               cap_col7;
    logic [7:0][DW-1:0] col_vec;

    assign IN_READY  = (state_q == S_IDLE) || (state_q == S_ROW_FEED);
    assign OUT_VALID = (state_q == S_OUTPUT);
    assign OUT_LAST  = OUT_VALID && (out_cnt_q == 3'd7);
    assign BUSY      = (state_q != S_IDLE);
    assign BF_DATA   = bf_data_q;

    assign in_hs  = IN_VALID && IN_READY;
    assign out_hs = OUT_VALID && OUT_READY;

    // The tag leaving the pipe lines up with the butterfly result on BF_OUT.
    assign tag_out  = tag_pipe_q[BF_LATENCY-1];
    assign cap_vld  = tag_out[4];
    assign cap_col  = tag_out[3];
    assign cap_idx  = tag_out[2:0];
    assign cap_row7 = cap_vld && !cap_col && (cap_idx == 3'd7);
    assign cap_col7 = cap_vld &&  cap_col && (cap_idx == 3'd7);

    // Column vector read from the buffer. Column 0 is issued on the very edge
    // that captures row 7, so a row result landing this cycle is forwarded
    // straight from BF_OUT instead of the not-yet-written buffer word.
    always_comb begin
        col_vec = '0;
        for (int r = 0; r < 8; r++) begin
            col_vec[r] = mem_q[r][col_cnt_q];
            if (cap_vld && !cap_col && (cap_idx == 3'(r))) begin
                col_vec[r] = BF_OUT[col_cnt_q];
            end
        end
    end

    always_comb begin
        OUT_ROW = '0;
        if (OUT_VALID) begin
            for (int v = 0; v < 8; v++) begin
                OUT_ROW[v] = mem_q[out_cnt_q][v];
            end
        end
    end

    // Next-state logic. BF_DATA defaults to zero so that every cycle without an
    // issued vector (idle, input gap, drain, output) drives zeros.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        out_cnt_d = out_cnt_q;
        bf_data_d = '0;
        bf_tag_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (in_hs) begin
                    bf_data_d = IN_ROW;
                    bf_tag_d  = {1'b1, 1'b0, 3'd0};
                    row_cnt_d = 3'd1;
                    col_cnt_d = 3'd0;
                    out_cnt_d = 3'd0;
                    state_d   = S_ROW_FEED;
                end
            end
            S_ROW_FEED: begin
                if (in_hs) begin
                    bf_data_d = IN_ROW;
                    bf_tag_d  = {1'b1, 1'b0, row_cnt_q};
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (row_cnt_q == 3'd7) begin
                        state_d = S_ROW_DRAIN;
                    end
                end
            end
            S_ROW_DRAIN: begin
                if (cap_row7) begin
                    bf_data_d = col_vec;
                    bf_tag_d  = {1'b1, 1'b1, col_cnt_q};
                    col_cnt_d = col_cnt_q + 3'd1;
                    state_d   = S_COL_FEED;
                end
            end
            S_COL_FEED: begin
                bf_data_d = col_vec;
                bf_tag_d  = {1'b1, 1'b1, col_cnt_q};
                col_cnt_d = col_cnt_q + 3'd1;
                if (col_cnt_q == 3'd7) begin
                    state_d = S_COL_DRAIN;
                end
            end
            S_COL_DRAIN: begin
                if (cap_col7) begin
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            row_cnt_q <= 3'd0;
            col_cnt_q <= 3'd0;
            out_cnt_q <= 3'd0;
            bf_data_q <= '0;
            bf_tag_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            out_cnt_q <= out_cnt_d;
            bf_data_q <= bf_data_d;
            bf_tag_q  <= bf_tag_d;
        end
    end

    // Clearing the tags on reset is what keeps late butterfly results from an
    // aborted block out of the buffer.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            tag_pipe_q[0] <= bf_tag_q;
            for (int i = 1; i < BF_LATENCY; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    // Row pass fills buffer row r; column pass j overwrites buffer column j.
    // Column j has already been issued before its own results come back.
    always_ff @(posedge CLOCK) begin
        if (cap_vld) begin
            if (!cap_col) begin
                for (int k = 0; k < 8; k++) begin
                    mem_q[cap_idx][k] <= BF_OUT[k];
                end
            end else begin
                for (int u = 0; u < 8; u++) begin
                    mem_q[u][cap_idx] <= BF_OUT[u];
                end
            end
        end
    end

`ifdef DCT_SEQ_PERF_CNT_EN
    logic [31:0] block_cnt_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            block_cnt_q <= 32'd0;
        end else if (out_hs && OUT_LAST) begin
            block_cnt_q <= block_cnt_q + 32'd1;
        end
    end

    assign BLOCK_COUNT = block_cnt_q;
`endif

endmodule

// File: tb/tb_dct_2d_sequencer.sv
`timescale 1ns/1ps
module tb_dct_2d_sequencer;

    localparam int DW = 32;
    localparam int L  = 5;

    logic                CLOCK = 1'b0;
    logic                RESET;
    logic                IN_VALID;
    logic                IN_READY;
    logic [7:0][DW-1:0]  IN_ROW;
    logic [7:0][DW-1:0]  BF_DATA;
    logic [7:0][DW-1:0]  BF_OUT;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic [7:0][DW-1:0]  OUT_ROW;
    logic                OUT_LAST;
    logic                BUSY;
`ifdef DCT_SEQ_PERF_CNT_EN
    logic [31:0]         BLOCK_COUNT;
`endif

    int n_vec = 0;
    int n_err = 0;
    int unsigned edges = 0;
    int unsigned first_hs = 0;
    int exp_blocks = 0;
    bit bf_mode = 1'b0;   // 0: DC-only stand-in butterfly, 1: identity

    dct_2d_sequencer #(.DW(DW), .BF_LATENCY(L)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_ROW    (IN_ROW),
        .BF_DATA   (BF_DATA),
        .BF_OUT    (BF_OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ROW   (OUT_ROW),
        .OUT_LAST  (OUT_LAST),
`ifdef DCT_SEQ_PERF_CNT_EN
        .BLOCK_COUNT(BLOCK_COUNT),
`endif
        .BUSY      (BUSY)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) edges++;

    // Stand-in butterfly with L register stages. Mode 0 keeps only the DC
    // term, out[0] = floor(sum * 181 / 512) ~ sum / sqrt(8); mode 1 passes data.
    logic [7:0][DW-1:0] bf_pipe [0:L-1];

    function automatic logic [7:0][DW-1:0] bf_fn(input logic [7:0][DW-1:0] d, input bit mode);
        logic [7:0][DW-1:0] o;
        longint unsigned    s;
        if (mode) return d;
        s = 0;
        for (int k = 0; k < 8; k++) s += d[k];
        o = '0;
        o[0] = DW'((s * 181) >> 9);
        return o;
    endfunction

    always @(posedge CLOCK) begin
        bf_pipe[0] <= bf_fn(BF_DATA, bf_mode);
        for (int i = 1; i < L; i++) bf_pipe[i] <= bf_pipe[i-1];
    end
    assign BF_OUT = bf_pipe[L-1];

    // kind 0: all 8 (DC), kind 1: all zero, kind 2: ramp r*8+k+1 (identity pass)
    function automatic logic [7:0][DW-1:0] mk_row(input int kind, input int r);
        logic [7:0][DW-1:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            if (kind == 0) v[k] = DW'(8);
            else if (kind == 2) v[k] = DW'(r * 8 + k + 1);
        end
        return v;
    endfunction

    function automatic logic [7:0][DW-1:0] exp_row(input int kind, input int u);
        logic [7:0][DW-1:0] v;
        v = '0;
        if (kind == 0 && u == 0) v[0] = DW'(62);
        if (kind == 2) v = mk_row(2, u);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives eight rows; with gaps, IN_VALID toggles 1/0.
    task automatic send_block(input int kind, input bit gaps);
        logic [7:0][DW-1:0] exp_bf;
        int r;
        int step;
        r = 0;
        step = 0;
        bf_mode = (kind == 2);
        while (r < 8 && step < 40) begin
            if (gaps && step[0]) begin
                IN_VALID = 1'b0;
                IN_ROW   = '0;
            end else begin
                IN_VALID = 1'b1;
                IN_ROW   = mk_row(kind, r);
            end
            @(posedge CLOCK);
            #1;
            if (IN_VALID) begin
                if (r == 0) first_hs = edges;
                exp_bf = IN_ROW;
                r++;
            end else begin
                exp_bf = '0;
            end
            IN_VALID = 1'b0;
            IN_ROW   = '0;
            @(negedge CLOCK);
            chk(gaps && step[0] ? "bf_data_gap" : "bf_data_row", BF_DATA, exp_bf);
            chk("in_ready_feed", IN_READY, r < 8);
            step++;
        end
    endtask

    // Called at a negedge. Collects eight rows, holding OUT_READY low for
    // stall_n cycles while row stall_row is presented.
    task automatic recv_block(input int kind, input int stall_row, input int stall_n,
                              input bit chk_lat);
        int u;
        int stalled;
        int steps;
        bit rdy;
        for (int w = 0; w < 200 && !OUT_VALID; w++) @(negedge CLOCK);
        chk("out_valid_wait", OUT_VALID, 1'b1);
        if (chk_lat) chk("first_out_cycle", edges - first_hs + 1, 27);
        u = 0;
        stalled = 0;
        steps = 0;
        while (u < 8 && steps < 40) begin
            chk("out_valid", OUT_VALID, 1'b1);
            chk("out_row", OUT_ROW, exp_row(kind, u));
            chk("out_last", OUT_LAST, u == 7);
            chk("in_ready_out", IN_READY, 1'b0);
            rdy = !(u == stall_row && stalled < stall_n);
            OUT_READY = rdy;
            @(posedge CLOCK);
            #1;
            if (rdy) u++;
            else stalled++;
            OUT_READY = 1'b1;
            @(negedge CLOCK);
            steps++;
        end
        chk("handshakes", u, 8);
        exp_blocks++;
        chk("idle_after", {BUSY, OUT_VALID, IN_READY}, 3'b001);
        chk("out_row_idle", OUT_ROW, '0);
`ifdef DCT_SEQ_PERF_CNT_EN
        chk("block_count", BLOCK_COUNT, exp_blocks);
`endif
    endtask

    initial begin
        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        IN_ROW    = '0;
        OUT_READY = 1'b1;
        repeat (6) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("rst_in_ready", IN_READY, 1'b1);
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_out_last", OUT_LAST, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_bf_data", BF_DATA, '0);
        chk("rst_out_row", OUT_ROW, '0);
`ifdef DCT_SEQ_PERF_CNT_EN
        chk("rst_block_count", BLOCK_COUNT, 0);
`endif
        RESET = 1'b0;
        @(negedge CLOCK);

        // DC block, back-to-back, no stall; first output in cycle 27.
        send_block(0, 1'b0);
        recv_block(0, -1, 0, 1'b1);

        // All-zero block with IN_VALID toggling each cycle.
        send_block(1, 1'b1);
        recv_block(1, -1, 0, 1'b0);

        // Ramp through an identity butterfly with gaps: output equals input,
        // which exposes any transposition or ordering error.
        send_block(2, 1'b1);
        recv_block(2, -1, 0, 1'b0);

        // DC block with a 3-cycle output stall on row 2.
        send_block(0, 1'b0);
        recv_block(0, 2, 3, 1'b0);

        // Reset in cycle 10 of a DC block, then an all-zero block.
        send_block(0, 1'b0);
        for (int w = 0; w < 20 && (edges - first_hs + 1) < 10; w++) @(negedge CLOCK);
        RESET = 1'b1;
        exp_blocks = 0;
        #1;
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_in_ready", IN_READY, 1'b1);
        chk("abort_bf_data", BF_DATA, '0);
        @(negedge CLOCK);
        RESET = 1'b0;
        send_block(1, 1'b0);
        recv_block(1, -1, 0, 1'b0);

        // Three back-to-back DC blocks after a clean reset.
        RESET = 1'b1;
        exp_blocks = 0;
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        for (int b = 0; b < 3; b++) begin
            send_block(0, 1'b0);
            recv_block(0, -1, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dct_2d_sequencer.md
# dct_2d_sequencer

Sequences one 8x8 two-dimensional DCT through the shared 8-point `dct_butterfly` datapath. It accepts eight input rows over a valid/ready handshake and pushes them through the butterfly. Results are collected into an internal transpose buffer, the buffer columns are pushed through the same butterfly, and the 8x8 coefficient block is emitted row-major over a second valid/ready handshake. It sits between the pixel/residual source and the quantiser, and owns the butterfly's `DATA` input and `OUT_DATA` output.

## Interface
- `DW`, 32, sample and coefficient width; must match the butterfly word width.
- `BF_LATENCY`, 5, cycles from a vector sitting on `BF_DATA` to its result appearing on `BF_OUT`; legal range 1..15.

Ports:
- `CLOCK` in 1: the single clock; all state changes on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `IN_VALID` in 1: `IN_ROW` holds a valid input row.
- `IN_READY` out 1: sequencer accepts a row this cycle.
- `IN_ROW` in `DW` x 8: input row, element 0 first.
- `BF_DATA` out `DW` x 8: registered vector driven to butterfly `DATA`.
- `BF_OUT` in `DW` x 8: butterfly `OUT_DATA`.
- `OUT_VALID` out 1: `OUT_ROW` holds a valid coefficient row.
- `OUT_READY` in 1: downstream accepts the row.
- `OUT_ROW` out `DW` x 8: coefficient row u, elements v=0..7.
- `OUT_LAST` out 1: high with row 7 of a block.
- `BUSY` out 1: state is not IDLE.

## Operation
- The FSM has six states: IDLE, ROW_FEED, ROW_DRAIN, COL_FEED, COL_DRAIN and OUTPUT.
- IDLE to ROW_FEED on the first input handshake.
- ROW_FEED to ROW_DRAIN on the 8th input handshake.
- ROW_DRAIN to COL_FEED when the row-7 result is captured.
- COL_FEED to COL_DRAIN after column 7 is driven.
- COL_DRAIN to OUTPUT when the column-7 result is captured.
- OUTPUT to IDLE on the row-7 output handshake.
- `IN_READY` = 1 in IDLE and ROW_FEED only. Handshake = `IN_VALID` & `IN_READY`. Gaps between input rows are allowed.
- Row accepted at edge t: `BF_DATA` <= `IN_ROW` at edge t, with row index r (0..7) counted per block.
- Tag pipeline: a `BF_LATENCY`-deep shift register carries {valid, pass, index} alongside each driven vector. When a tag emerges, `BF_OUT` is captured:
  - Row pass r: `buf[r][k]` <= `BF_OUT[k]`.
  - Column pass j: `buf[u][j]` <= `BF_OUT[u]`.
- The single 64-word buffer is reused. Column j is read before its results are written, and `BF_LATENCY` >= 1 guarantees this.
- COL_FEED drives column j = {`buf[0][j]` .. `buf[7][j]`} on `BF_DATA` for eight consecutive cycles, j=0..7, with no gaps.
- OUTPUT presents `OUT_ROW` = `buf[u][0..7]` for u=0..7. u advances only on `OUT_VALID` & `OUT_READY`. Row and data stay stable while stalled.
- `BF_DATA` is driven to 0 in every cycle that no vector is issued (idle, input gap, drain, output). The butterfly runs freely; untagged results are ignored.
- The sequencer does no arithmetic; all data passes through bit-exact.
- `OUT_ROW` = 0 whenever `OUT_VALID` = 0.

## Timing
- Reset values:
  - `IN_READY` = 1 (IDLE).
  - `OUT_VALID`, `OUT_LAST` and `BUSY` = 0.
  - `BF_DATA` and `OUT_ROW` = 0.
  - Tag pipeline and counters cleared.
  - Buffer contents are not reset.
- Take the first input handshake edge as cycle 0, with inputs back-to-back and L = `BF_LATENCY`:
  - Row r sits on `BF_DATA` in cycle r+1 and is captured at the end of cycle r+1+L.
  - Column j is driven in cycle 9+L+j.
  - `OUT_VALID` first rises in cycle 17+2L (27 at default).
- With no output stall, the block completes 8 cycles later. The next block is accepted from the following IDLE cycle.
- `RESET` mid-block aborts immediately:
  - Partial block is discarded.
  - FSM returns to IDLE.
  - In-flight tags are cleared, so stale butterfly results are never captured.
- `IN_VALID` while `IN_READY` = 0 is held off and causes no state change.

## Configuration
- `DCT_SEQ_PERF_CNT_EN` defined: adds output port `BLOCK_COUNT` (32 bits).
  - Reset value 0; increments by 1 on each row-7 output handshake.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- DC block, all 64 inputs = 8, `OUT_READY` = 1 → row 0 = {62,0,0,0,0,0,0,0}, rows 1..7 all 0, `OUT_LAST` with row 7, `OUT_VALID` rising in cycle 27.
- All-zero block with `IN_VALID` toggling 1/0 each cycle → 8 zero rows. `BF_DATA` = 0 in the gap cycles and the output is identical to the gap-free run.
- DC block with `OUT_READY` low for 3 cycles at row 2 → row 2 held stable, no row skipped or duplicated, 8 handshakes total.
- `RESET` pulsed in cycle 10 of a DC block, then an all-zero block → all-zero output, with no stale value of 22 or 62 captured.
- Three back-to-back blocks with `DCT_SEQ_PERF_CNT_EN` defined → `BLOCK_COUNT` reads 1, 2, 3 after each `OUT_LAST` handshake. `IN_READY` = 0 throughout OUTPUT.
